// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer_if
//  Description : Bundles the instruction-memory fetch port and the ALU
//                operand/result port that sit between alu_sequencer and
//                its neighbours.
//                  imem_addr/imem_rd  : fetch address and read strobe
//                  imem_data          : 12-bit instruction, valid the cycle
//                                       after imem_rd
//                  alu_a/alu_b/alu_op : operands and opcode to the ALU
//                  alu_ce             : ALU enable
//                  alu_carry_we       : carry write enable
//                  alu_result/alu_carry : ALU outputs fed back
//                master = sequencer side, slave = memory/ALU side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_sequencer_if;
    logic [7:0]  imem_addr;
    logic        imem_rd;
    logic [11:0] imem_data;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic        alu_ce;
    logic        alu_carry_we;
    logic [7:0]  alu_result;
    logic        alu_carry;

    modport master (
        output imem_addr, imem_rd, alu_a, alu_b, alu_op, alu_ce, alu_carry_we,
        input  imem_data, alu_result, alu_carry
    );

    modport slave (
        input  imem_addr, imem_rd, alu_a, alu_b, alu_op, alu_ce, alu_carry_we,
        output imem_data, alu_result, alu_carry
    );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Fetch/decode/execute control stage in front of the 8-bit
//                ALU. Owns PC, IR, accumulator and carry flag; every
//                instruction takes exactly three cycles (FETCH, DECODE,
//                EXECUTE) with no overlap.
//  Ports       : clk        - rising-edge clock
//                rst_n      - asynchronous active-low reset
//                run        - level; starts/continues execution
//                bus        - fetch + ALU port (master side)
//                acc        - accumulator
//                carry_flag - registered carry (written by ADD only)
//                halted     - high once a HALT instruction has executed
//  Instruction : [11:8] op, [7:0] imm
//                0x0-0x7 ALU op (op[2:0] forwarded), codes 6/7 are LOAD
//                0x8 JMP, 0x9 JC, 0xA-0xE NOP, 0xF HALT
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    alu_sequencer_if.master        bus,
    output logic [7:0]             acc,
    output logic                   carry_flag,
    output logic                   halted
);

    // FSM encoding
    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_FETCH   = 3'd1;
    localparam logic [2:0] c_ST_DECODE  = 3'd2;
    localparam logic [2:0] c_ST_EXECUTE = 3'd3;
    localparam logic [2:0] c_ST_HALT    = 3'd4;

    // ALU opcode encoding (matches the downstream ALU package)
    localparam logic [2:0] c_OP_ADD     = 3'd0;
    localparam logic [2:0] c_OP_LAST    = 3'd5;   // highest real ALU code

    localparam logic [3:0] c_OP_JMP     = 4'h8;
    localparam logic [3:0] c_OP_JC      = 4'h9;
    localparam logic [3:0] c_OP_HALT    = 4'hF;

    logic [2:0]  r_state;
    logic [7:0]  r_pc;
    logic [11:0] r_ir;
    logic [7:0]  r_acc;
    logic        r_carry;

    logic [3:0]  w_op;
    logic [7:0]  w_imm;
    logic        w_is_alu;
    logic        w_is_load;
    logic        w_is_add;
    logic        w_is_jmp;
    logic        w_is_jc;
    logic        w_is_halt;
    logic        w_exec;

    assign w_op      = r_ir[11:8];
    assign w_imm     = r_ir[7:0];
    // Codes 6 and 7 have no ALU meaning and are repurposed as LOAD.
    assign w_is_alu  = ~w_op[3] && (w_op[2:0] <= c_OP_LAST);
    assign w_is_load = ~w_op[3] && (w_op[2:0] >  c_OP_LAST);
    assign w_is_add  = w_is_alu && (w_op[2:0] == c_OP_ADD);
    assign w_is_jmp  = (w_op == c_OP_JMP);
    assign w_is_jc   = (w_op == c_OP_JC);
    assign w_is_halt = (w_op == c_OP_HALT);
    assign w_exec    = (r_state == c_ST_EXECUTE);

    // Datapath outputs are pure functions of the architectural registers.
    assign bus.imem_addr    = r_pc;
    assign bus.imem_rd      = (r_state == c_ST_FETCH);
    assign bus.alu_a        = r_acc;
    assign bus.alu_b        = w_imm;
    assign bus.alu_op       = r_ir[10:8];
    assign bus.alu_ce       = w_exec && w_is_alu;
    // The ALU only defines carry_out for ADD, so only ADD may write it.
    assign bus.alu_carry_we = w_exec && w_is_add;

    assign acc        = r_acc;
    assign carry_flag = r_carry;
    assign halted     = (r_state == c_ST_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_pc    <= 8'h00;
            r_ir    <= 12'h000;
            r_acc   <= 8'h00;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (run) begin
                        r_state <= c_ST_FETCH;
                    end
                end
                c_ST_FETCH: begin
                    r_state <= c_ST_DECODE;
                end
                c_ST_DECODE: begin
                    r_ir    <= bus.imem_data;
                    r_pc    <= r_pc + 8'd1;
                    r_state <= c_ST_EXECUTE;
                end
                c_ST_EXECUTE: begin
                    if (w_is_alu) begin
                        r_acc <= bus.alu_result;
                    end
                    if (w_is_load) begin
                        r_acc <= w_imm;
                    end
                    if (w_is_add) begin
                        r_carry <= bus.alu_carry;
                    end
                    // PC already advanced in DECODE; a taken branch overrides it.
                    if (w_is_jmp || (w_is_jc && r_carry)) begin
                        r_pc <= w_imm;
                    end
                    if (w_is_halt) begin
                        r_state <= c_ST_HALT;
                    end else if (run) begin
                        r_state <= c_ST_FETCH;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_HALT: begin
                    r_state <= c_ST_HALT;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Directed self-checking bench for alu_sequencer. Provides a
//                synchronous instruction memory and a combinational ALU
//                model on the slave side of the interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [7:0]  acc;
    logic        carry_flag;
    logic        halted;

    logic [11:0] mem [0:255];

    int n_checks = 0;
    int n_errors = 0;

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .bus        (bus.master),
        .acc        (acc),
        .carry_flag (carry_flag),
        .halted     (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous instruction memory: data appears the cycle after imem_rd.
    always @(posedge clk) begin
        if (bus.imem_rd) begin
            bus.imem_data <= mem[bus.imem_addr];
        end
    end

    // ALU model. For non-ADD ops carry_out is "undefined"; drive the inverse
    // of the current flag so any illegal carry write becomes visible.
    always_comb begin
        bus.alu_result = 8'h00;
        bus.alu_carry  = ~carry_flag;
        case (bus.alu_op)
            3'd0: {bus.alu_carry, bus.alu_result} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            3'd1: bus.alu_result = bus.alu_a - bus.alu_b;
            3'd2: bus.alu_result = bus.alu_a & bus.alu_b;
            3'd3: bus.alu_result = bus.alu_a | bus.alu_b;
            3'd4: bus.alu_result = bus.alu_a ^ bus.alu_b;
            3'd5: bus.alu_result = ~bus.alu_a;
            default: bus.alu_result = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then sample 1 time unit later.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            mem[i] = 12'hA00;
        end
    endtask

    // Reset, release, then raise run on a falling edge; the next rising edge
    // is edge 1 (IDLE samples run=1).
    task automatic start_prog();
        run   = 1'b0;
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        run   = 1'b0;
        clear_mem();

        // ---------------- Reset state ----------------
        tick(2);
        check("rst_imem_addr", bus.imem_addr, 8'h00);
        check("rst_imem_rd",   bus.imem_rd, 1'b0);
        check("rst_alu_ce",    bus.alu_ce, 1'b0);
        check("rst_carry_we",  bus.alu_carry_we, 1'b0);
        check("rst_alu_a",     bus.alu_a, 8'h00);
        check("rst_alu_b",     bus.alu_b, 8'h00);
        check("rst_alu_op",    bus.alu_op, 3'd0);
        check("rst_acc",       acc, 8'h00);
        check("rst_carry",     carry_flag, 1'b0);
        check("rst_halted",    halted, 1'b0);

        // ---------------- LOAD 0x3C ; ADD 0x05 ----------------
        clear_mem();
        mem[0] = 12'h63C;
        mem[1] = 12'h005;
        start_prog();
        tick(1);
        check("la_fetch0_rd",   bus.imem_rd, 1'b1);
        check("la_fetch0_addr", bus.imem_addr, 8'h00);
        tick(3);
        check("la_acc_load",    acc, 8'h3C);
        check("la_fetch1_rd",   bus.imem_rd, 1'b1);
        check("la_fetch1_addr", bus.imem_addr, 8'h01);
        tick(2);
        check("la_exec_ce",     bus.alu_ce, 1'b1);
        check("la_exec_cwe",    bus.alu_carry_we, 1'b1);
        check("la_exec_a",      bus.alu_a, 8'h3C);
        check("la_exec_b",      bus.alu_b, 8'h05);
        check("la_exec_op",     bus.alu_op, 3'd0);
        tick(1);
        check("la_acc_add",     acc, 8'h41);
        check("la_carry",       carry_flag, 1'b0);
        check("la_ce_off",      bus.alu_ce, 1'b0);

        // ---------------- Carry, JC taken, AND keeps carry, HALT ----------------
        clear_mem();
        mem[8'h00] = 12'h6F0;   // LOAD F0
        mem[8'h01] = 12'h020;   // ADD 20
        mem[8'h02] = 12'h940;   // JC 40
        mem[8'h40] = 12'h2FF;   // AND FF
        mem[8'h41] = 12'hF00;   // HALT
        start_prog();
        tick(7);
        check("cy_acc",        acc, 8'h10);
        check("cy_carry",      carry_flag, 1'b1);
        tick(3);
        check("cy_jc_addr",    bus.imem_addr, 8'h40);
        check("cy_jc_rd",      bus.imem_rd, 1'b1);
        tick(3);
        check("cy_and_acc",    acc, 8'h10);
        check("cy_and_carry",  carry_flag, 1'b1);
        tick(2);
        check("hl_not_yet",    halted, 1'b0);
        tick(1);
        check("hl_halted",     halted, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("hl_no_fetch", bus.imem_rd, 1'b0);
        end
        check("hl_still",      halted, 1'b1);
        check("hl_acc_kept",   acc, 8'h10);
        rst_n = 1'b0;
        #1;
        check("hl_rst_clear",  halted, 1'b0);

        // ---------------- JC not taken, JMP FF wrap ----------------
        clear_mem();
        mem[8'h00] = 12'h810;   // JMP 10
        mem[8'h10] = 12'h955;   // JC 55 (carry=0)
        mem[8'h11] = 12'h8FF;   // JMP FF
        mem[8'hFF] = 12'hA00;   // NOP
        start_prog();
        tick(4);
        check("jmp_addr_10",   bus.imem_addr, 8'h10);
        tick(3);
        check("jc_nt_addr_11", bus.imem_addr, 8'h11);
        tick(3);
        check("jmp_addr_ff",   bus.imem_addr, 8'hFF);
        tick(3);
        check("wrap_addr_00",  bus.imem_addr, 8'h00);
        check("wrap_rd",       bus.imem_rd, 1'b1);

        // ---------------- Run pause during DECODE ----------------
        clear_mem();
        mem[0] = 12'h63C;
        mem[1] = 12'h005;
        start_prog();
        tick(2);                // now in DECODE
        run = 1'b0;
        tick(2);
        check("pz_acc",        acc, 8'h3C);
        check("pz_idle_rd",    bus.imem_rd, 1'b0);
        tick(3);
        check("pz_hold_rd",    bus.imem_rd, 1'b0);
        check("pz_hold_addr",  bus.imem_addr, 8'h01);
        @(negedge clk);
        run = 1'b1;
        tick(1);
        check("pz_resume_rd",  bus.imem_rd, 1'b1);
        check("pz_resume_addr", bus.imem_addr, 8'h01);
        tick(3);
        check("pz_resume_acc", acc, 8'h41);

        // ---------------- Async reset during EXECUTE of ADD 05 ----------------
        clear_mem();
        mem[0] = 12'h005;
        start_prog();
        tick(3);
        check("ar_in_exec",    bus.alu_ce, 1'b1);
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        check("ar_ce",         bus.alu_ce, 1'b0);
        check("ar_cwe",        bus.alu_carry_we, 1'b0);
        check("ar_addr",       bus.imem_addr, 8'h00);
        check("ar_alu_b",      bus.alu_b, 8'h00);
        check("ar_acc",        acc, 8'h00);
        tick(2);
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);
        check("ar_idle_rd",    bus.imem_rd, 1'b0);
        check("ar_idle_acc",   acc, 8'h00);
        check("ar_idle_addr",  bus.imem_addr, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
